clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//  Parametrised multi-channel programmable clock divider; generalises the fixed 2^23 divider.
//  Each channel derives a square-wave enable clock and a 1-cycle tick strobe from CLOCK_50.
//  Divisors can be reprogrammed at run time without glitches; all channels share one clock domain.
//  Sits between the board clock and slow logic (display scan, debouncers, blinkers).
// PARAMETERS
//  NUM_CH       4         number of independent divider channels (1..16)
//  CNT_W        24        divisor/counter width in bits
//  DEFAULT_DIV  8388608   divisor loaded at reset into every channel (50 MHz / 2^23 ~ 6 Hz)
//  CH_W         $clog2(NUM_CH) (min 1)   width of cfg_ch
// PORTS
//  CLOCK_50   in   1        system clock; all logic on posedge
//  reset_n    in   1        asynchronous, active-low reset
//  en         in   NUM_CH   per-channel run enable
//  sync_clr   in   1        synchronous phase clear, all channels
//  cfg_valid  in   1        divisor-write request
//  cfg_ready  out  1        divisor-write accept; transfer when cfg_valid & cfg_ready
//  cfg_ch     in   CH_W     target channel of the write
//  cfg_div    in   CNT_W    new divisor D (period in CLOCK_50 cycles)
//  pending    out  NUM_CH   channel holds an accepted, not-yet-applied divisor
//  clk_out    out  NUM_CH   divided square wave, driven directly from flops
//  tick       out  NUM_CH   1-cycle strobe, last cycle of each period, from flops
// BEHAVIOUR
//  Reset (reset_n=0, immediate): div=DEFAULT_DIV, cnt=0, pending=0, clk_out=0, tick=0, cfg_ready=1.
//  Divisor rule: effective D = max(cfg_div, 2); values 0 and 1 saturate to 2. No error flag.
//  Period: with en=1, cnt runs 0..D-1 and wraps to 0; one step per CLOCK_50 edge.
//  Outputs during a cycle in which cnt==k: clk_out = (k >= D>>1), tick = (k == D-1).
//   -> low for D>>1 cycles, high for D-(D>>1) cycles; odd D gives the extra cycle high.
//   -> Outputs are registered (decoded one cycle ahead from next-cnt); no comb. path to ports.
//  Enable: en=0 -> cnt cleared to 0, clk_out=0, tick=0. Rising en restarts the period at k=0.
//  Write handshake: cfg_ready = ~pending[cfg_ch] (comb. from cfg_ch); accepted write stores
//   cfg_div in shadow[ch] and sets pending[ch]. cfg_ch >= NUM_CH: ready=1, write dropped.
//  Apply point: shadow->div and pending cleared on the tick cycle of that channel
//   (next period uses new D), or on the next edge if en[ch]=0, or on sync_clr.
//  sync_clr=1: all cnt<=0, clk_out<=0, tick<=0, pending divisors applied; wins over
//   counting. A write accepted in the same cycle as sync_clr is applied at that edge too.
//  Accept and apply in the same cycle for one channel: the new write is applied; pending stays 0.
//  Counter width: cnt and D are CNT_W bits; D never exceeds 2^CNT_W-1, so no overflow.
//  Channels fully independent except shared cfg port and sync_clr.
// STRUCTURE
//  Package clk_div_pkg: MIN_DIV=2, function sat_div(d) (max(d,2)), default CNT_W.
//  Sub-module clk_div_chan (one per channel, generate loop): cnt, div, shadow, pending,
//   output flops; ports clk, rst_n, en, clr, wr, wr_div, pending, clk_out, tick.
//  Top: cfg decode/ready mux, sync_clr fan-out, output concatenation.
// TESTING
//  1 Reset, DEFAULT_DIV=8, en=1: clk_out 0000_1111 repeating, tick at k=7, period 8.
//  2 Write D=5 to ch1 mid-period: pending[1]=1, old period completes, then 2 low/3 high.
//  3 Write D=0 and D=1 -> behaves as D=2: clk_out toggles every cycle, tick every 2nd cycle.
//  4 Second write to ch1 while pending -> cfg_ready=0, held until tick; then accepted.
//  5 sync_clr during k=3 on all channels -> all cnt=0 next cycle, phases aligned, pending applied.
//  6 Assert reset_n=0 between edges mid-period -> outputs 0 immediately; en low -> outputs 0, restart at k=0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and divisor saturation helper for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned MIN_DIV   = 2;
  localparam int          DEF_CNT_W = 24;

  // Divisors below MIN_DIV would give a period with no high or no low phase.
  function automatic logic [31:0] sat_div(input logic [31:0] d);
    if (d < 32'(MIN_DIV)) begin
      return 32'(MIN_DIV);
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, live and shadow divisor, registered
// square-wave and tick outputs decoded from the next counter value.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = 8388608
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] wr_sat_s;
  logic             run_s;

  // Next-state: a period boundary (tick, disable or clear) is the only place the divisor changes.
  always_comb begin
    wr_sat_s  = CNT_W'(sat_div(32'(wr_div)));
    cnt_d     = cnt_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    run_s     = 1'b0;
    if (clr || !en || (cnt_q == div_q - CNT_W'(1))) begin
      cnt_d     = '0;
      pending_d = 1'b0;
      run_s     = en & ~clr;
      if (wr) begin
        div_d = wr_sat_s;
      end else if (pending_q) begin
        div_d = shadow_q;
      end else begin
        div_d = div_q;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      run_s = 1'b1;
      if (wr) begin
        shadow_d  = wr_sat_s;
        pending_d = 1'b1;
      end else begin
        shadow_d  = shadow_q;
      end
    end
    clk_out_d = run_s && (cnt_d >= (div_d >> 1));
    tick_d    = run_s && (cnt_d == div_d - CNT_W'(1));
  end

  // Channel state and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= CNT_W'(DEFAULT_DIV);
      shadow_q  <= '0;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending = pending_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: shared divisor-write port with
// per-channel back-pressure, common phase clear, one clk_div_chan per channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = 8388608,
  parameter int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] wr_s;
  logic [NUM_CH-1:0] pending_s;
  logic              ready_s;

  // Ready mux and write decode; an out-of-range channel is always ready and its write is dropped.
  always_comb begin
    ready_s = 1'b1;
    wr_s    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        ready_s = ~pending_s[i];
        wr_s[i] = cfg_valid & ~pending_s[i];
      end else begin
        wr_s[i] = 1'b0;
      end
    end
  end

  assign cfg_ready = ready_s;
  assign pending   = pending_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (CLOCK_50),
      .rst_n   (reset_n),
      .en      (en[g]),
      .clr     (sync_clr),
      .wr      (wr_s[g]),
      .wr_div  (cfg_div),
      .pending (pending_s[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: hand-derived vector table for reset
// and saturated divisors, then model-scored sequences for the timing corner cases.
module tb_clk_div_multi;

  localparam int NCH  = 3;
  localparam int CW   = 24;
  localparam int DDIV = 8;

  logic            CLOCK_50 = 1'b0;
  logic            reset_n;
  logic [NCH-1:0]  en;
  logic            sync_clr;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_ch;
  logic [CW-1:0]   cfg_div;
  logic [NCH-1:0]  pending;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  tick;

  always #5 CLOCK_50 = ~CLOCK_50;

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .CLOCK_50 (CLOCK_50), .reset_n (reset_n), .en (en), .sync_clr (sync_clr),
    .cfg_valid (cfg_valid), .cfg_ready (cfg_ready), .cfg_ch (cfg_ch), .cfg_div (cfg_div),
    .pending (pending), .clk_out (clk_out), .tick (tick)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: per-channel phase k and divisor D; outputs follow directly from (k, D).
  int m_k[NCH];
  int m_d[NCH];
  int m_sh[NCH];
  bit m_pend[NCH];
  bit m_acc;

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_k[i] = 0; m_d[i] = DDIV; m_sh[i] = 0; m_pend[i] = 1'b0;
    end
  endtask

  function automatic bit m_ready(input int ch);
    return (ch >= NCH) ? 1'b1 : !m_pend[ch];
  endfunction

  task automatic m_step(input logic [NCH-1:0] e, input bit clr, input bit val, input int ch, input int dv);
    int sat;
    bit w;
    sat   = (dv < 2) ? 2 : dv;
    m_acc = val && m_ready(ch);
    for (int i = 0; i < NCH; i++) begin
      w = m_acc && (ch == i);
      if (clr || !e[i] || (m_k[i] == m_d[i] - 1)) begin
        m_k[i] = 0;
        if (w) m_d[i] = sat;
        else if (m_pend[i]) m_d[i] = m_sh[i];
        m_pend[i] = 1'b0;
      end else begin
        m_k[i]++;
        if (w) begin m_sh[i] = sat; m_pend[i] = 1'b1; end
      end
    end
  endtask

  typedef struct {
    logic [NCH-1:0] c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
  } exp_t;

  function automatic exp_t m_expect();
    exp_t r;
    for (int i = 0; i < NCH; i++) begin
      r.c[i] = (m_k[i] >= m_d[i] / 2);
      r.t[i] = (m_k[i] == m_d[i] - 1);
      r.p[i] = m_pend[i];
    end
    return r;
  endfunction

  exp_t sb_q[$];

  // One clock cycle: drive, check ready, push expectation, clock, pop and compare.
  task automatic cyc(input logic [NCH-1:0] e, input bit clr, input bit val, input logic [1:0] ch,
                     input logic [CW-1:0] dv, input bit use_tab, input exp_t tab_exp,
                     input bit tab_rdy, input string nm);
    exp_t ex;
    en = e; sync_clr = clr; cfg_valid = val; cfg_ch = ch; cfg_div = dv;
    #1;
    chk({nm, ".ready"}, 32'(cfg_ready), 32'(use_tab ? tab_rdy : m_ready(int'(ch))));
    m_step(e, clr, val, int'(ch), int'(dv));
    sb_q.push_back(use_tab ? tab_exp : m_expect());
    @(posedge CLOCK_50);
    #1;
    ex = sb_q.pop_front();
    chk({nm, ".clk_out"}, 32'(clk_out), 32'(ex.c));
    chk({nm, ".tick"},    32'(tick),    32'(ex.t));
    chk({nm, ".pending"}, 32'(pending), 32'(ex.p));
  endtask

  task automatic idle(input logic [NCH-1:0] e, input string nm);
    exp_t z;
    z = '{c: '0, t: '0, p: '0};
    cyc(e, 1'b0, 1'b0, 2'd0, 24'd0, 1'b0, z, 1'b0, nm);
  endtask

  typedef struct {
    bit             val;
    logic [1:0]     ch;
    logic [CW-1:0]  dv;
    logic [NCH-1:0] c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
    bit             rdy;
  } vec_t;

  vec_t tab[32];

  initial begin
    logic [15:0] c_pat;
    logic [15:0] t_pat;
    exp_t        te;
    int          stall;
    bit          done;

    // Reset period 8: after the first edge k=1; high for k=4..7, tick at k=7.
    c_pat = 16'h7878;
    t_pat = 16'h4040;
    for (int i = 0; i < 16; i++) begin
      tab[i] = '{1'b0, 2'd0, 24'd0, {NCH{c_pat[i]}}, {NCH{t_pat[i]}}, 3'b000, 1'b1};
    end
    tab[16] = '{1'b1, 2'd2, 24'd0, 3'b000, 3'b000, 3'b100, 1'b1};
    tab[17] = '{1'b1, 2'd0, 24'd1, 3'b000, 3'b000, 3'b101, 1'b1};
    tab[18] = '{1'b1, 2'd3, 24'd5, 3'b000, 3'b000, 3'b101, 1'b1};
    tab[19] = '{1'b0, 2'd0, 24'd0, 3'b111, 3'b000, 3'b101, 1'b0};
    tab[20] = '{1'b0, 2'd0, 24'd0, 3'b111, 3'b000, 3'b101, 1'b0};
    tab[21] = '{1'b0, 2'd0, 24'd0, 3'b111, 3'b000, 3'b101, 1'b0};
    tab[22] = '{1'b0, 2'd0, 24'd0, 3'b111, 3'b111, 3'b101, 1'b0};
    tab[23] = '{1'b0, 2'd0, 24'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    tab[24] = '{1'b0, 2'd0, 24'd0, 3'b101, 3'b101, 3'b000, 1'b1};
    tab[25] = '{1'b0, 2'd0, 24'd0, 3'b000, 3'b000, 3'b000, 1'b1};
    tab[26] = '{1'b0, 2'd0, 24'd0, 3'b101, 3'b101, 3'b000, 1'b1};
    tab[27] = '{1'b0, 2'd0, 24'd0, 3'b010, 3'b000, 3'b000, 1'b1};
    tab[28] = '{1'b0, 2'd0, 24'd0, 3'b111, 3'b101, 3'b000, 1'b1};
    tab[29] = '{1'b0, 2'd0, 24'd0, 3'b010, 3'b000, 3'b000, 1'b1};
    tab[30] = '{1'b0, 2'd0, 24'd0, 3'b111, 3'b111, 3'b000, 1'b1};
    tab[31] = '{1'b0, 2'd0, 24'd0, 3'b000, 3'b000, 3'b000, 1'b1};

    reset_n = 1'b0; en = 3'b111; sync_clr = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 24'd0;
    m_reset();
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    chk("reset.clk_out", 32'(clk_out), 32'd0);
    chk("reset.tick",    32'(tick),    32'd0);
    chk("reset.pending", 32'(pending), 32'd0);
    chk("reset.ready",   32'(cfg_ready), 32'd1);
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      te = '{c: tab[i].c, t: tab[i].t, p: tab[i].p};
      cyc(3'b111, 1'b0, tab[i].val, tab[i].ch, tab[i].dv, 1'b1, te, tab[i].rdy, $sformatf("tab%0d", i));
    end

    // Mid-period write to ch1, then a second write held off until the first is applied.
    te = '{c: '0, t: '0, p: '0};
    for (int i = 0; i < 3; i++) idle(3'b111, "pre_wr");
    cyc(3'b111, 1'b0, 1'b1, 2'd1, 24'd5, 1'b0, te, 1'b0, "wr5");
    stall = 0;
    done  = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      cyc(3'b111, 1'b0, 1'b1, 2'd1, 24'd6, 1'b0, te, 1'b0, "wr6_hold");
      if (m_acc) done = 1'b1;
      else stall++;
    end
    chk("wr6.accepted", 32'(done), 32'd1);
    chk("wr6.stall_cycles", 32'(stall), 32'd4);
    for (int i = 0; i < 14; i++) idle(3'b111, "run56");

    // Phase clear at k=3 of ch1 with a pending divisor and a same-cycle write.
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (m_k[1] == 2) done = 1'b1;
      else idle(3'b111, "seek_k2");
    end
    chk("seek_k2.found", 32'(done), 32'd1);
    cyc(3'b111, 1'b0, 1'b1, 2'd1, 24'd7, 1'b0, te, 1'b0, "wr7");
    chk("pre_clr.pending1", 32'(pending[1]), 32'd1);
    cyc(3'b111, 1'b1, 1'b1, 2'd2, 24'd3, 1'b0, te, 1'b0, "sync_clr");
    chk("clr.pending", 32'(pending), 32'd0);
    chk("clr.clk_out", 32'(clk_out), 32'd0);
    for (int i = 0; i < 16; i++) idle(3'b111, "post_clr");

    // Disable ch1 for a few cycles, then restart from k=0.
    for (int i = 0; i < 3; i++) idle(3'b101, "en_off");
    for (int i = 0; i < 10; i++) idle(3'b111, "en_on");

    // Asynchronous reset between edges.
    #3;
    reset_n = 1'b0;
    #1;
    chk("areset.clk_out", 32'(clk_out), 32'd0);
    chk("areset.tick",    32'(tick),    32'd0);
    chk("areset.pending", 32'(pending), 32'd0);
    chk("areset.ready",   32'(cfg_ready), 32'd1);
    m_reset();
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) idle(3'b111, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
